// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_encoder: packs RV32I field descriptors (R/load/store/branch) into     |
// | 32-bit words written to consecutive instruction-memory addresses. Rev 1.0  |
// +----------------------------------------------------------------------------+
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] KIND_R     = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_BR    = 2'd3;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t              state_q;
  logic                last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W:0]     count_q;
  logic                err_q;

  logic [31:0]         enc_d;
  logic                bad_d;

  // I/S immediates must sign-fit in 12 bits; B offsets must be even.
  always_comb begin
    enc_d = '0;
    bad_d = 1'b0;
    case (in_kind)
      KIND_R: begin
        enc_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      KIND_LOAD: begin
        enc_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        bad_d = in_imm[12] ^ in_imm[11];
      end
      KIND_STORE: begin
        enc_d = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        bad_d = in_imm[12] ^ in_imm[11];
      end
      KIND_BR: begin
        enc_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OP_BR};
        bad_d = in_imm[0];
      end
      default: begin
        enc_d = '0;
        bad_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCEPT;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (bad_d) begin
              err_q   <= 1'b1;
              state_q <= FINISH;
            end else begin
              wdata_q <= enc_d;
              last_q  <= in_last;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          count_q <= count_q + 1'b1;
          if (last_q) begin
            state_q <= FINISH;
          end else if (addr_q == ADDR_MAX) begin
            err_q   <= 1'b1;
            state_q <= FINISH;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= ACCEPT;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ACCEPT);
  assign mem_we    = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_encoder: scoreboard bench for instr_encoder (8-bit and 2-bit      |
// | address instances sharing one descriptor stream). Rev 1.0                  |
// +----------------------------------------------------------------------------+
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [1:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [12:0] in_imm = '0;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;

  int nerr = 0;
  int nchk = 0;
  int nwr = 0;
  int s_nwr = 0;
  int exp_addr = 0;
  logic [39:0] exp_q[$];
  logic [39:0] s_exp_q[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: instruction word built from field positions with shifts.
  function automatic logic [31:0] ref_word(input logic [1:0] k, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [12:0] imm);
    int unsigned u, base;
    u    = imm;
    base = (int'(rs1) << 15) | (int'(f3) << 12);
    case (k)
      2'd0:    return base | (int'(f7) << 25) | (int'(rs2) << 20) | (int'(rd) << 7) | 32'h33;
      2'd1:    return base | ((u & 32'hFFF) << 20) | (int'(rd) << 7) | 32'h03;
      2'd2:    return base | (((u >> 5) & 32'h7F) << 25) | (int'(rs2) << 20)
                           | ((u & 32'h1F) << 7) | 32'h23;
      default: return base | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
                           | (int'(rs2) << 20) | (((u >> 1) & 32'hF) << 8)
                           | (((u >> 11) & 1) << 7) | 32'h63;
    endcase
  endfunction

  function automatic bit ref_ok(input logic [1:0] k, input logic [12:0] imm);
    int s;
    s = $signed(imm);
    if (k == 2'd1 || k == 2'd2) return (s >= -2048) && (s <= 2047);
    if (k == 2'd3) return (s % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [12:0] rand_imm(input logic [1:0] k);
    logic [12:0] r;
    r = 13'($urandom);
    if (k == 2'd1 || k == 2'd2) r[12] = r[11];
    if (k == 2'd3) r[0] = 1'b0;
    return r;
  endfunction

  // Returns #1 after the accepting edge, i.e. inside the cycle after the handshake.
  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [12:0] imm, input logic last, input bit sm, input int gap);
    bit got;
    int i;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    if (ref_ok(k, imm)) begin
      if (sm) s_exp_q.push_back({8'(exp_addr), ref_word(k, rd, rs1, rs2, f3, f7, imm)});
      else    exp_q.push_back({8'(exp_addr), ref_word(k, rd, rs1, rs2, f3, f7, imm)});
      exp_addr++;
    end
    got = 1'b0;
    i = 0;
    while (!got && i < 100) begin
      if (sm ? s_in_ready : in_ready) got = 1'b1;
      else begin
        @(negedge clk);
        i++;
      end
    end
    if (!got) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic start_load(input bit sm);
    @(negedge clk);
    if (sm) s_start = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_start = 1'b0;
    exp_addr = 0;
    chk("start_in_ready", {31'd0, sm ? s_in_ready : in_ready}, 32'd1);
    chk("start_busy",     {31'd0, sm ? s_busy : busy}, 32'd1);
    chk("start_err_clr",  {31'd0, sm ? s_err : err}, 32'd0);
    chk("start_count",    sm ? {29'd0, s_count} : {23'd0, count}, 32'd0);
  endtask

  // Called #1 after the last accept edge E; checks cycles E+2 and E+3.
  task automatic finish_check(input int n, input int last_addr);
    @(posedge clk);
    #1;
    chk("fin_done",  {31'd0, done}, 32'd1);
    chk("fin_busy",  {31'd0, busy}, 32'd1);
    chk("fin_count", {23'd0, count}, 32'(n));
    chk("fin_addr",  {24'd0, mem_addr}, 32'(last_addr));
    chk("fin_err",   {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic err_check(input string name);
    int w0;
    w0 = nwr;
    chk({name, "_err"},   {31'd0, err}, 32'd1);
    chk({name, "_done"},  {31'd0, done}, 32'd1);
    chk({name, "_we"},    {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_done_low"}, {31'd0, done}, 32'd0);
    chk({name, "_idle"},     {31'd0, busy}, 32'd0);
    chk({name, "_sticky"},   {31'd0, err}, 32'd1);
    chk({name, "_nowrite"},  32'(nwr), 32'(w0));
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (mem_we) begin
      nwr++;
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h, no write required", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (s_mem_we) begin
      s_nwr++;
      if (s_exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL s_write_unexpected: got addr 0x%0h data 0x%0h, no write required", s_mem_addr, s_mem_wdata);
      end else begin
        e = s_exp_q.pop_front();
        chk("s_wr_addr", {30'd0, s_mem_addr}, {24'd0, e[39:32]});
        chk("s_wr_data", s_mem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] k;
    int w0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_addr",     {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata",    mem_wdata, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    chk("rst_err",      {31'd0, err}, 32'd0);
    chk("rst_count",    {23'd0, count}, 32'd0);

    // add x3,x1,x2 as a one-word program
    start_load(0);
    send(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 0, 0);
    chk("add_we",    {31'd0, mem_we}, 32'd1);
    chk("add_word",  mem_wdata, 32'h002081B3);
    finish_check(1, 0);

    // four-instruction program with gaps; a start mid-load must be ignored
    w0 = nwr;
    start_load(0);
    send(2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 1'b0, 0, 2);
    chk("lw_word", mem_wdata, 32'h00812283);
    send(2'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12, 1'b0, 0, 1);
    chk("sw_word", mem_wdata, 32'h00512623);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b0, 0, 3);
    chk("beq_word", mem_wdata, 32'hFE208EE3);
    send(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b1, 0, 0);
    finish_check(4, 3);
    chk("prog4_strobes", 32'(nwr - w0), 32'd4);

    // illegal branch offset, then out-of-range load immediate
    start_load(0);
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3, 1'b0, 0, 0);
    err_check("br_odd");
    start_load(0);
    send(2'd1, 5'd4, 5'd1, 5'd0, 3'd2, 7'd0, 13'h0800, 1'b1, 0, 1);
    err_check("ld_range");

    // randomized program, unused fields randomized too
    start_load(0);
    for (int i = 0; i < 10; i++) begin
      k = 2'($urandom);
      send(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
           rand_imm(k), (i == 9), 0, $urandom_range(0, 3));
    end
    finish_check(10, 9);

    // overflow on a 4-word memory
    start_load(1);
    for (int i = 0; i < 4; i++) begin
      k = 2'($urandom);
      send(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
           rand_imm(k), 1'b0, 1, $urandom_range(0, 2));
    end
    chk("ovf_we",   {31'd0, s_mem_we}, 32'd1);
    chk("ovf_addr", {30'd0, s_mem_addr}, 32'd3);
    @(posedge clk);
    #1;
    chk("ovf_err",   {31'd0, s_err}, 32'd1);
    chk("ovf_done",  {31'd0, s_done}, 32'd1);
    chk("ovf_count", {29'd0, s_count}, 32'd4);
    chk("ovf_hold",  {30'd0, s_mem_addr}, 32'd3);
    @(posedge clk);
    #1;
    chk("ovf_idle",   {31'd0, s_busy}, 32'd0);
    chk("ovf_writes", 32'(s_nwr), 32'd4);

    // reset while the second word is being written
    start_load(0);
    send(2'd0, 5'd7, 5'd6, 5'd5, 3'd1, 7'd32, 13'd0, 1'b0, 0, 0);
    send(2'd1, 5'd8, 5'd9, 5'd0, 3'd2, 7'd0, 13'd100, 1'b0, 0, 1);
    chk("mid_we",   {31'd0, mem_we}, 32'd1);
    chk("mid_addr", {24'd0, mem_addr}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_ctl",   {22'd0, in_ready, mem_we, busy, done, err, count}, 32'd0);
    chk("arst_addr",  {24'd0, mem_addr}, 32'd0);
    chk("arst_wdata", mem_wdata, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    in_kind = 2'd1; in_rd = 5'd10; in_rs1 = 5'd11; in_rs2 = 5'd0;
    in_funct3 = 3'd2; in_funct7 = 7'd0; in_imm = 13'h1FF0; in_last = 1'b1;
    in_valid = 1'b1;
    w0 = nwr;
    repeat (3) @(negedge clk);
    chk("held_idle",    {31'd0, busy}, 32'd0);
    chk("held_nowrite", 32'(nwr), 32'(w0));
    start_load(0);
    send(2'd1, 5'd10, 5'd11, 5'd0, 3'd2, 7'd0, 13'h1FF0, 1'b1, 0, 0);
    finish_check(1, 0);

    repeat (2) @(negedge clk);
    chk("sb_empty",   32'(exp_q.size()), 32'd0);
    chk("s_sb_empty", 32'(s_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
